// File: rtl/s2p_com_align.sv
// Serial-to-parallel front end: COM-symbol byte alignment, lock, held byte output.
// Optional: define S2P_COM_COUNT_EN to add the com_count output.
module s2p_com_align #(
  parameter logic [7:0]  COM_SYMBOL = 8'hBC,
  parameter int unsigned COM_LOCK   = 4
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        data_in,
  output logic [7:0]  data_8,
  output logic        valid_8,
  output logic        active,
`ifdef S2P_COM_COUNT_EN
  output logic [15:0] com_count,
`endif
  output logic        sinc
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [4:0] LOCK_N = 5'(COM_LOCK);

  state_t      state, state_n;
  logic [7:0]  sr, nsr;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [3:0]  com_cnt, com_cnt_n;
  logic [4:0]  com_inc;
  logic [7:0]  data_n;
  logic        valid_n;
  logic        sinc_n;
  logic        is_com;
  logic        boundary;

  always_comb begin
    nsr       = {sr[6:0], data_in};
    is_com    = (nsr == COM_SYMBOL);
    boundary  = (bit_cnt == 3'd7);
    com_inc   = {1'b0, com_cnt} + 5'd1;
    state_n   = state;
    bit_cnt_n = bit_cnt;
    com_cnt_n = com_cnt;
    data_n    = data_8;
    valid_n   = valid_8;
    sinc_n    = 1'b0;
    unique case (state)
      SEARCH: begin
        if (is_com) begin
          bit_cnt_n = 3'd0;
          com_cnt_n = 4'd1;
          state_n   = (LOCK_N == 5'd1) ? ACTIVE : ALIGN;
        end
      end
      ALIGN: begin
        bit_cnt_n = bit_cnt + 3'd1;
        if (boundary) begin
          if (is_com) begin
            com_cnt_n = com_inc[3:0];
            if (com_inc == LOCK_N) state_n = ACTIVE;
          end else begin
            // misaligned byte: restart the bitwise hunt from the next bit
            state_n   = SEARCH;
            com_cnt_n = 4'd0;
            bit_cnt_n = 3'd0;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_n = bit_cnt + 3'd1;
        if (boundary) begin
          data_n  = nsr;
          valid_n = ~is_com;
          sinc_n  = 1'b1;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state   <= SEARCH;
      sr      <= 8'd0;
      bit_cnt <= 3'd0;
      com_cnt <= 4'd0;
      data_8  <= 8'd0;
      valid_8 <= 1'b0;
      sinc    <= 1'b0;
      active  <= 1'b0;
    end else begin
      state   <= state_n;
      sr      <= nsr;
      bit_cnt <= bit_cnt_n;
      com_cnt <= com_cnt_n;
      data_8  <= data_n;
      valid_8 <= valid_n;
      sinc    <= sinc_n;
      active  <= (state_n == ACTIVE);
    end
  end

`ifdef S2P_COM_COUNT_EN
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      com_count <= 16'd0;
    end else if (state == ACTIVE && boundary && is_com
                 && com_count != 16'hFFFF) begin
      com_count <= com_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_s2p_com_align.sv
// Directed bench for s2p_com_align: lock, payload, realign, reset, COM_LOCK=1.
module tb_s2p_com_align;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_8, data_8_1;
  logic       valid_8, valid_8_1;
  logic       active, active_1;
  logic       sinc, sinc_1;
`ifdef S2P_COM_COUNT_EN
  logic [15:0] com_count, com_count_1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_32f = ~clk_32f;

  s2p_com_align dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .data_8   (data_8),
    .valid_8  (valid_8),
    .active   (active),
`ifdef S2P_COM_COUNT_EN
    .com_count(com_count),
`endif
    .sinc     (sinc)
  );

  s2p_com_align #(.COM_LOCK(1)) dut1 (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .data_8   (data_8_1),
    .valid_8  (valid_8_1),
    .active   (active_1),
`ifdef S2P_COM_COUNT_EN
    .com_count(com_count_1),
`endif
    .sinc     (sinc_1)
  );

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    reset = 1'b1;
    repeat (2) @(posedge clk_32f);
    #1;
    @(negedge clk_32f);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_32f);
    reset   = 1'b1;
    data_in = 1'b1;
    repeat (2) @(posedge clk_32f);
    #1;
    n_cmp++;
    if ({data_8, valid_8, active, sinc} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_outs got %h want 000", {data_8, valid_8, active, sinc});
    end
    @(negedge clk_32f);
    reset   = 1'b0;
    data_in = 1'b0;
  endtask

  task automatic test_lock();
    logic [7:0] b;
    int bad;
    b = 8'hBC;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(b[i]);
        if (!(k == 3 && i == 0))
          if ({active, valid_8, sinc} !== 3'b000) bad++;
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL prelock_quiet got %0d active/valid/sinc hits want 0", bad);
    end
    n_cmp++;
    if ({active, valid_8, sinc} !== 3'b100) begin
      n_err++;
      $display("FAIL lock_edge got a/v/s=%b want 100", {active, valid_8, sinc});
    end
  endtask

  task automatic test_payload();
    logic [7:0] b;
    int bad;
    b = 8'h5A;
    bad = 0;
    for (int i = 7; i >= 1; i--) begin
      send_bit(b[i]);
      if (sinc !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL early_sinc got %0d pulses want 0", bad);
    end
    send_bit(b[0]);
    n_cmp++;
    if ({data_8, valid_8, sinc, active} !== {8'h5A, 3'b111}) begin
      n_err++;
      $display("FAIL byte_5a got %h/%b%b%b want 5a/111", data_8, valid_8, sinc, active);
    end
    b = 8'hC3;
    send_bit(b[7]);
    n_cmp++;
    if ({data_8, valid_8, sinc} !== {8'h5A, 2'b10}) begin
      n_err++;
      $display("FAIL hold_5a got %h/%b%b want 5a/10", data_8, valid_8, sinc);
    end
    for (int i = 6; i >= 0; i--) send_bit(b[i]);
    n_cmp++;
    if ({data_8, valid_8, sinc} !== {8'hC3, 2'b11}) begin
      n_err++;
      $display("FAIL byte_c3 got %h/%b%b want c3/11", data_8, valid_8, sinc);
    end
  endtask

  task automatic test_com_byte();
`ifdef S2P_COM_COUNT_EN
    n_cmp++;
    if (com_count !== 16'd0) begin
      n_err++;
      $display("FAIL com_count_pre got %0d want 0", com_count);
    end
`endif
    send_byte(8'hBC);
    n_cmp++;
    if ({data_8, valid_8, sinc} !== {8'hBC, 2'b01}) begin
      n_err++;
      $display("FAIL com_out got %h/%b%b want bc/01", data_8, valid_8, sinc);
    end
`ifdef S2P_COM_COUNT_EN
    n_cmp++;
    if (com_count !== 16'd1) begin
      n_err++;
      $display("FAIL com_count_post got %0d want 1", com_count);
    end
`endif
  endtask

  task automatic test_reset_mid();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk_32f);
    reset = 1'b1;
    @(posedge clk_32f);
    #1;
    n_cmp++;
    if ({data_8, valid_8, active, sinc} !== 11'd0) begin
      n_err++;
      $display("FAIL mid_reset got %h want 000", {data_8, valid_8, active, sinc});
    end
`ifdef S2P_COM_COUNT_EN
    n_cmp++;
    if (com_count !== 16'd0) begin
      n_err++;
      $display("FAIL mid_reset_cnt got %0d want 0", com_count);
    end
`endif
    @(negedge clk_32f);
    reset = 1'b0;
    repeat (3) send_byte(8'hBC);
    n_cmp++;
    if (active !== 1'b0) begin
      n_err++;
      $display("FAIL relock_3com got active=%b want 0", active);
    end
    send_byte(8'hBC);
    n_cmp++;
    if (active !== 1'b1) begin
      n_err++;
      $display("FAIL relock_4com got active=%b want 1", active);
    end
  endtask

  task automatic test_realign();
    do_reset();
    repeat (3) send_bit(1'b0);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h7F);
    n_cmp++;
    if (active !== 1'b0) begin
      n_err++;
      $display("FAIL abandon_7f got active=%b want 0", active);
    end
    repeat (3) send_byte(8'hBC);
    n_cmp++;
    if (active !== 1'b0) begin
      n_err++;
      $display("FAIL realign_3com got active=%b want 0", active);
    end
    send_byte(8'hBC);
    n_cmp++;
    if (active !== 1'b1) begin
      n_err++;
      $display("FAIL realign_4com got active=%b want 1", active);
    end
  endtask

  task automatic test_lock1();
    logic [7:0] b;
    int bad;
    do_reset();
    b = 8'hBC;
    bad = 0;
    for (int i = 7; i >= 1; i--) begin
      send_bit(b[i]);
      if (active_1 !== 1'b0) bad++;
    end
    send_bit(b[0]);
    n_cmp++;
    if (bad != 0 || {active_1, valid_8_1, sinc_1} !== 3'b100) begin
      n_err++;
      $display("FAIL lock1_edge got a/v/s=%b early=%0d want 100/0",
               {active_1, valid_8_1, sinc_1}, bad);
    end
    send_byte(8'h5A);
    n_cmp++;
    if ({data_8_1, valid_8_1, sinc_1} !== {8'h5A, 2'b11}) begin
      n_err++;
      $display("FAIL lock1_byte got %h/%b%b want 5a/11", data_8_1, valid_8_1, sinc_1);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_payload();
    test_com_byte();
    test_reset_mid();
    test_realign();
    test_lock1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
